writeback_sel_pipe: RTL and testbench

WRITEBACK_SEL_PIPE -- requirements
Module: writeback_sel_pipe

---
 rtl/writeback_sel_pipe.sv | 125 ++++++++++++
 tb/tb_writeback_sel_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_sel_pipe.sv
// Writeback source selector feeding a 2-entry in-order skid queue.
// Optional saturating illegal-select counter enabled by WRITEBACK_SEL_PIPE_ERR_CNT_EN.
module writeback_sel_pipe #(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 11,
    parameter int SEL_W     = 4,
    parameter int CONST_IDX = 2,
    parameter int CONST_VAL = 227
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_sel_err,
    output logic                     out_valid,
`ifdef WRITEBACK_SEL_PIPE_ERR_CNT_EN
    output logic [7:0]               err_count,
`endif
    input  logic                     out_ready
);

    if ((2 ** SEL_W) < NUM_SRC || NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_params
        $error("writeback_sel_pipe: illegal NUM_SRC/SEL_W combination");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  head_data;
    logic              head_err;
    logic [WIDTH-1:0]  tail_data;
    logic              tail_err;

    logic [WIDTH-1:0]  sel_data;
    logic              sel_err;
    logic [31:0]       sel_ext;
    logic              accept;
    logic              pop;

    assign sel_ext = 32'(sel);

    // Every slot is read through the loop so the constant override below stays lint-quiet.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_ext == k) begin
                sel_data = src_bus[k*WIDTH +: WIDTH];
            end
        end
        if (sel_ext == CONST_IDX) begin
            sel_data = WIDTH'(CONST_VAL);
        end
        if (sel_ext >= NUM_SRC) begin
            sel_data = '0;
            sel_err  = 1'b1;
        end
    end

    assign in_ready    = (state != FULL) && !reset;
    assign out_valid   = (state != EMPTY);
    assign out_data    = head_data;
    assign out_sel_err = head_err;
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid && out_ready;

    // Head always holds the oldest entry; tail is only occupied in FULL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            head_data <= '0;
            head_err  <= 1'b0;
            tail_data <= '0;
            tail_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_data <= sel_data;
                        head_err  <= sel_err;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_data <= sel_data;
                        head_err  <= sel_err;
                    end else if (accept) begin
                        tail_data <= sel_data;
                        tail_err  <= sel_err;
                        state     <= FULL;
                    end else if (pop) begin
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_err  <= tail_err;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef WRITEBACK_SEL_PIPE_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (accept && sel_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_sel_pipe.sv
// Scoreboard bench for writeback_sel_pipe: stimulus pushes expectations, a monitor pops on handshake.
// Honours WRITEBACK_SEL_PIPE_ERR_CNT_EN to also model err_count.
module tb_writeback_sel_pipe;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 11;
    localparam int SEL_W   = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    logic                     clk;
    logic                     reset;
    logic [NUM_SRC*WIDTH-1:0] src_bus;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_sel_err;
    logic                     out_valid;
    logic                     out_ready;
`ifdef WRITEBACK_SEL_PIPE_ERR_CNT_EN
    logic [7:0]               err_count;
`endif

    exp_t sb[$];
    int   checks;
    int   errors;
    int   err_model;

    writeback_sel_pipe #(
        .WIDTH    (WIDTH),
        .NUM_SRC  (NUM_SRC),
        .SEL_W    (SEL_W),
        .CONST_IDX(2),
        .CONST_VAL(227)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_bus    (src_bus),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sel_err(out_sel_err),
        .out_valid  (out_valid),
`ifdef WRITEBACK_SEL_PIPE_ERR_CNT_EN
        .err_count  (err_count),
`endif
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slot(input int k, input logic [WIDTH-1:0] v);
        src_bus[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic set_out_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    // Presents one request, waits (bounded) for in_ready, and records the expected head value.
    task automatic apply_stimulus(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] exp_d,
                                  input logic exp_e);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        sel      = s;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_output("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.data = exp_d;
        e.err  = exp_e;
        sb.push_back(e);
        if (exp_e && err_model < 255) err_model++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: compares the head against the scoreboard whenever the consumer takes it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("pop_data", out_data, e.data);
                    check_output("pop_err", 32'(out_sel_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        err_model = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        src_bus   = '0;
        for (int k = 0; k < NUM_SRC; k++) set_slot(k, 32'hA000_0000 + 32'(k));
        set_slot(0, 32'h11);
        set_slot(1, 32'h22);
        set_slot(2, 32'hFFFF_FFFF);

        repeat (2) @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_out_data", out_data, 32'd0);
        check_output("rst_out_err", 32'(out_sel_err), 32'd0);
`ifdef WRITEBACK_SEL_PIPE_ERR_CNT_EN
        check_output("rst_err_count", 32'(err_count), 32'd0);
`endif
        reset = 1'b0;

        // Constant source, one-cycle latency from EMPTY.
        apply_stimulus(4'd2, 32'd227, 1'b0);
        check_output("lat_out_valid", 32'(out_valid), 32'd1);
        check_output("lat_out_data", out_data, 32'd227);
        check_output("lat_out_err", 32'(out_sel_err), 32'd0);

        // Every legal source, back to back.
        for (int k = 0; k < NUM_SRC; k++) begin
            if (k == 2) apply_stimulus(4'(k), 32'd227, 1'b0);
            else if (k == 0) apply_stimulus(4'(k), 32'h11, 1'b0);
            else if (k == 1) apply_stimulus(4'(k), 32'h22, 1'b0);
            else apply_stimulus(4'(k), 32'hA000_0000 + 32'(k), 1'b0);
        end

        // Stored entry must not follow later src_bus changes and must hold while stalled.
        set_out_ready(1'b0);
        set_slot(8, 32'hDEAD_BEEF);
        apply_stimulus(4'd8, 32'hDEAD_BEEF, 1'b0);
        set_slot(8, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("hold_data", out_data, 32'hDEAD_BEEF);
        end
        set_out_ready(1'b1);
        repeat (2) @(posedge clk);

        // Fill to FULL, confirm backpressure, then drain in order.
        set_out_ready(1'b0);
        apply_stimulus(4'd0, 32'h11, 1'b0);
        apply_stimulus(4'd1, 32'h22, 1'b0);
        @(negedge clk);
        check_output("full_in_ready", 32'(in_ready), 32'd0);
        check_output("full_head", out_data, 32'h11);
        set_out_ready(1'b1);
        repeat (3) @(posedge clk);

        // Illegal selects, including the first out-of-range index.
        apply_stimulus(4'd13, 32'd0, 1'b1);
        check_output("illegal_data", out_data, 32'd0);
        check_output("illegal_err", 32'(out_sel_err), 32'd1);
`ifdef WRITEBACK_SEL_PIPE_ERR_CNT_EN
        check_output("err_count_one", 32'(err_count), 32'd1);
`endif
        apply_stimulus(4'd11, 32'd0, 1'b1);
        apply_stimulus(4'd10, 32'hA000_000A, 1'b0);
        for (int i = 0; i < 300; i++) apply_stimulus((i % 2 == 0) ? 4'd15 : 4'd12, 32'd0, 1'b1);
        @(negedge clk);
`ifdef WRITEBACK_SEL_PIPE_ERR_CNT_EN
        check_output("err_count_sat", 32'(err_count), 32'(err_model));
`endif

        // Reset while FULL discards everything immediately.
        set_out_ready(1'b0);
        apply_stimulus(4'd3, 32'hA000_0003, 1'b0);
        apply_stimulus(4'd4, 32'hA000_0004, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("mid_rst_valid", 32'(out_valid), 32'd0);
        check_output("mid_rst_data", out_data, 32'd0);
        check_output("mid_rst_err", 32'(out_sel_err), 32'd0);
        check_output("mid_rst_ready", 32'(in_ready), 32'd0);
`ifdef WRITEBACK_SEL_PIPE_ERR_CNT_EN
        check_output("mid_rst_cnt", 32'(err_count), 32'd0);
`endif
        sb.delete();
        err_model = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("post_rst_valid", 32'(out_valid), 32'd0);
        check_output("post_rst_ready", 32'(in_ready), 32'd1);
        set_out_ready(1'b1);
        apply_stimulus(4'd5, 32'hA000_0005, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_output("drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
